// File: rtl/acc_adder.sv
// acc_adder: single-stage registered adder / subtractor / accumulator with a
// valid/ready handshake on both sides.
//
// Parameters
//   P_WIDTH  operand width
//   P_ACC_W  result / accumulator width (must be >= P_WIDTH+1)
//   P_SAT    accumulate overflow policy: 0 wrap, 1 saturate to all-ones
//
// Ports
//   i_clk, i_rst_n          clock, async active-low reset
//   i_valid / o_ready       operation handshake (i_mode, i_a, i_b)
//   i_mode                  00 ADD, 01 SUB, 10 ACC, 11 CLR
//   o_valid / i_ready       result handshake (o_result, o_carry)
//   o_acc                   live accumulator register
//   o_ovf_sticky            accumulate overflow seen since last CLR / reset
module acc_adder #(
  parameter int P_WIDTH = 4,
  parameter int P_ACC_W = 8,
  parameter int P_SAT   = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [1:0]         i_mode,
  input  logic [P_WIDTH-1:0] i_a,
  input  logic [P_WIDTH-1:0] i_b,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [P_ACC_W-1:0] o_result,
  output logic               o_carry,
  output logic [P_ACC_W-1:0] o_acc,
  output logic               o_ovf_sticky
);

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;
  localparam logic [1:0] MODE_CLR = 2'b11;

  typedef struct packed {
    logic [P_ACC_W-1:0] result;
    logic               carry;
  } resp_t;

  resp_t              resp_q, resp_d;
  logic               vld_q;
  logic [P_ACC_W-1:0] acc_q, acc_d;
  logic               stk_q, stk_d;
  logic               accept;

  logic [P_WIDTH:0]   sum;
  logic [P_WIDTH-1:0] diff;
  logic [P_ACC_W:0]   acc_sum;
  logic               acc_ovf;

  // The output register can take a new beat when it is empty or being
  // drained this cycle, so a consume and an accept can share one edge.
  assign o_ready = !vld_q || i_ready;
  assign accept  = i_valid && o_ready;

  assign sum     = {1'b0, i_a} + {1'b0, i_b};
  assign diff    = i_a - i_b;
  // One extra bit catches accumulator overflow. A saturated accumulator
  // overflows again for any nonzero addend, which keeps reporting it.
  assign acc_sum = {1'b0, acc_q} + (P_ACC_W+1)'(i_a);
  assign acc_ovf = acc_sum[P_ACC_W];

  always_comb begin
    resp_d = resp_q;
    acc_d  = acc_q;
    stk_d  = stk_q;
    case (i_mode)
      MODE_ADD: begin
        resp_d.result = P_ACC_W'(sum);
        resp_d.carry  = sum[P_WIDTH];
      end
      MODE_SUB: begin
        resp_d.result = P_ACC_W'(diff);
        resp_d.carry  = (i_a < i_b);
      end
      MODE_ACC: begin
        if (acc_ovf && (P_SAT != 0)) acc_d = '1;
        else                         acc_d = acc_sum[P_ACC_W-1:0];
        resp_d.result = acc_d;
        resp_d.carry  = acc_ovf;
        stk_d         = stk_q | acc_ovf;
      end
      MODE_CLR: begin
        resp_d.result = '0;
        resp_d.carry  = 1'b0;
        acc_d         = '0;
        stk_d         = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q  <= 1'b0;
      resp_q <= '0;
      acc_q  <= '0;
      stk_q  <= 1'b0;
    end else if (accept) begin
      vld_q  <= 1'b1;
      resp_q <= resp_d;
      acc_q  <= acc_d;
      stk_q  <= stk_d;
    end else if (i_ready) begin
      // Drained with nothing behind it; the data registers keep their value.
      vld_q  <= 1'b0;
    end
  end

  assign o_valid      = vld_q;
  assign o_result     = resp_q.result;
  assign o_carry      = resp_q.carry;
  assign o_acc        = acc_q;
  assign o_ovf_sticky = stk_q;

endmodule

// File: tb/tb_acc_adder.sv
module tb_acc_adder;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_valid;
  logic       i_ready;
  logic [1:0] i_mode;
  logic [3:0] i_a, i_b;

  // w_* : wrapping instance, s_* : saturating instance, same stimulus
  logic       w_ready, w_valid, w_carry, w_stk;
  logic [7:0] w_result, w_acc;
  logic       s_ready, s_valid, s_carry, s_stk;
  logic [7:0] s_result, s_acc;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, CLR = 2'b11;

  acc_adder #(.P_WIDTH(4), .P_ACC_W(8), .P_SAT(0)) dut_w (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(w_ready),
    .i_mode(i_mode), .i_a(i_a), .i_b(i_b), .o_valid(w_valid), .i_ready(i_ready),
    .o_result(w_result), .o_carry(w_carry), .o_acc(w_acc), .o_ovf_sticky(w_stk));

  acc_adder #(.P_WIDTH(4), .P_ACC_W(8), .P_SAT(1)) dut_s (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(s_ready),
    .i_mode(i_mode), .i_a(i_a), .i_b(i_b), .o_valid(s_valid), .i_ready(i_ready),
    .o_result(s_result), .o_carry(s_carry), .o_acc(s_acc), .o_ovf_sticky(s_stk));

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one operation with the consumer ready; sample 1ns after the edge.
  task automatic op(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b);
    i_valid = 1'b1; i_ready = 1'b1; i_mode = m; i_a = a; i_b = b;
    @(posedge i_clk); #1;
  endtask

  task automatic idle();
    i_valid = 1'b0;
  endtask

  task automatic chk_w(input string n, input logic [7:0] r, input logic c,
                       input logic [7:0] acc, input logic stk);
    chk({n, "_w_vld"}, 32'(w_valid), 32'd1);
    chk({n, "_w_res"}, 32'(w_result), 32'(r));
    chk({n, "_w_cry"}, 32'(w_carry), 32'(c));
    chk({n, "_w_acc"}, 32'(w_acc), 32'(acc));
    chk({n, "_w_stk"}, 32'(w_stk), 32'(stk));
  endtask

  task automatic chk_s(input string n, input logic [7:0] r, input logic c,
                       input logic [7:0] acc, input logic stk);
    chk({n, "_s_vld"}, 32'(s_valid), 32'd1);
    chk({n, "_s_res"}, 32'(s_result), 32'(r));
    chk({n, "_s_cry"}, 32'(s_carry), 32'(c));
    chk({n, "_s_acc"}, 32'(s_acc), 32'(acc));
    chk({n, "_s_stk"}, 32'(s_stk), 32'(stk));
  endtask

  // CLR, 4 x ACC 15 = 60, ACC 4 -> accumulator 0x40, result held valid.
  task automatic build40();
    op(CLR, 4'd0, 4'd0);
    for (int k = 0; k < 4; k++) op(ACC, 4'd15, 4'd0);
    op(ACC, 4'd4, 4'd0);
    chk_w("build40", 8'h40, 1'b0, 8'h40, 1'b0);
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [3:0] a, b;
    logic [7:0] res;
    logic       c;
    logic [7:0] acc;
    logic       stk;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{ADD, 4'd15, 4'd1, 8'h10, 1'b1, 8'h00, 1'b0};
    vecs[1]  = '{ADD, 4'd3,  4'd4, 8'h07, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{SUB, 4'd3,  4'd5, 8'h0E, 1'b1, 8'h00, 1'b0};
    vecs[3]  = '{SUB, 4'd5,  4'd3, 8'h02, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{SUB, 4'd7,  4'd7, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{ACC, 4'd15, 4'd9, 8'h0F, 1'b0, 8'h0F, 1'b0};
    vecs[6]  = '{ACC, 4'd0,  4'd3, 8'h0F, 1'b0, 8'h0F, 1'b0};
    vecs[7]  = '{ACC, 4'd1,  4'd0, 8'h10, 1'b0, 8'h10, 1'b0};
    vecs[8]  = '{ADD, 4'd8,  4'd8, 8'h10, 1'b1, 8'h10, 1'b0};
    vecs[9]  = '{SUB, 4'd0,  4'd15, 8'h01, 1'b1, 8'h10, 1'b0};
    vecs[10] = '{CLR, 4'd9,  4'd9, 8'h00, 1'b0, 8'h00, 1'b0};

    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_mode = ADD; i_a = 4'd0; i_b = 4'd0;

    // Reset state, with an op presented that must not be taken
    i_valid = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_vld", 32'(w_valid), 32'd0);
    chk("rst_res", 32'(w_result), 32'd0);
    chk("rst_acc", 32'(s_acc), 32'd0);
    chk("rst_stk", 32'(w_stk), 32'd0);
    chk("rst_rdy", 32'(w_ready), 32'd1);
    i_valid = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Table: one op per cycle, consumer always ready; no overflow so both agree
    for (int i = 0; i < 11; i++) begin
      op(vecs[i].mode, vecs[i].a, vecs[i].b);
      chk_w($sformatf("vec%0d", i), vecs[i].res, vecs[i].c, vecs[i].acc, vecs[i].stk);
      chk($sformatf("vec%0d_s_res", i), 32'(s_result), 32'(vecs[i].res));
    end

    // Drain with nothing behind: o_valid drops, registers hold
    idle();
    @(posedge i_clk); #1;
    chk("drain_vld", 32'(w_valid), 32'd0);
    chk("drain_acc", 32'(w_acc), 32'd0);

    // 18 back-to-back ACC 15 after CLR: wrap vs saturate on beat 18
    op(CLR, 4'd0, 4'd0);
    for (int k = 1; k <= 18; k++) begin
      op(ACC, 4'd15, 4'd0);
      if (k < 18) begin
        chk_w($sformatf("acc%0d", k), 8'(15 * k), 1'b0, 8'(15 * k), 1'b0);
        chk($sformatf("acc%0d_s_res", k), 32'(s_result), 32'(15 * k));
      end else begin
        chk_w("acc18", 8'h0E, 1'b1, 8'h0E, 1'b1);
        chk_s("acc18", 8'hFF, 1'b1, 8'hFF, 1'b1);
      end
    end
    // Saturated: adding 0 is no overflow; adding 1 overflows again
    op(ACC, 4'd0, 4'd0);
    chk_w("sat_add0", 8'h0E, 1'b0, 8'h0E, 1'b1);
    chk_s("sat_add0", 8'hFF, 1'b0, 8'hFF, 1'b1);
    op(ACC, 4'd1, 4'd0);
    chk_w("sat_add1", 8'h0F, 1'b0, 8'h0F, 1'b1);
    chk_s("sat_add1", 8'hFF, 1'b1, 8'hFF, 1'b1);
    // CLR after overflow clears sticky and emits a zero beat
    op(CLR, 4'd5, 4'd5);
    chk_w("clr_ovf", 8'h00, 1'b0, 8'h00, 1'b0);
    chk_s("clr_ovf", 8'h00, 1'b0, 8'h00, 1'b0);

    // Backpressure: 5 stalled cycles with an ACC 1 waiting
    build40();
    i_ready = 1'b0; i_valid = 1'b1; i_mode = ACC; i_a = 4'd1; i_b = 4'd0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d_rdy", k), 32'(w_ready), 32'd0);
      @(posedge i_clk); #1;
      chk($sformatf("bp%0d_vld", k), 32'(w_valid), 32'd1);
      chk($sformatf("bp%0d_res", k), 32'(w_result), 32'h40);
      chk($sformatf("bp%0d_acc", k), 32'(w_acc), 32'h40);
    end
    i_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", 32'(w_ready), 32'd1);
    @(posedge i_clk); #1;
    chk_w("bp_rel", 8'h41, 1'b0, 8'h41, 1'b0);

    // Reset mid-operation between edges, result pending and acc 0x40
    build40();
    i_valid = 1'b0; i_ready = 1'b0;
    @(negedge i_clk); #1;
    i_rst_n = 1'b0;
    #1;
    chk("mrst_vld", 32'(w_valid), 32'd0);
    chk("mrst_res", 32'(w_result), 32'd0);
    chk("mrst_cry", 32'(w_carry), 32'd0);
    chk("mrst_acc", 32'(w_acc), 32'd0);
    chk("mrst_stk", 32'(w_stk), 32'd0);
    chk("mrst_rdy", 32'(w_ready), 32'd1);
    chk("mrst_s_acc", 32'(s_acc), 32'd0);
    #1;
    i_rst_n = 1'b1;
    // First edge after release accepts immediately
    op(ADD, 4'd1, 4'd1);
    chk_w("post_rst", 8'h02, 1'b0, 8'h00, 1'b0);
    idle();
    @(posedge i_clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_adder.md
ACC_ADDER -- requirements
Module: acc_adder

Interface
REQ-001 SHALL have parameter P_WIDTH, default 4: operand width in bits.
REQ-002 SHALL have parameter P_ACC_W, default 8: result and accumulator width; P_ACC_W >= P_WIDTH+1 is required.
REQ-003 SHALL have parameter P_SAT, default 0: accumulate overflow policy, 0 = wrap, 1 = saturate.
REQ-004 SHALL have port i_clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port i_valid, input, 1: an operation is presented.
REQ-007 SHALL have port o_ready, output, 1: the block can accept an operation this cycle.
REQ-008 SHALL have port i_mode, input, 2: 00 ADD, 01 SUB, 10 ACC, 11 CLR.
REQ-009 SHALL have ports i_a and i_b, input, P_WIDTH each: unsigned operands.
REQ-010 SHALL have port o_valid, output, 1: o_result and o_carry are valid.
REQ-011 SHALL have port i_ready, input, 1: the downstream consumer accepts the result.
REQ-012 SHALL have port o_result, output, P_ACC_W: registered result.
REQ-013 SHALL have port o_carry, output, 1: carry, borrow or overflow of the held result.
REQ-014 SHALL have port o_acc, output, P_ACC_W: current accumulator register.
REQ-015 SHALL have port o_ovf_sticky, output, 1: at least one accumulate overflow has occurred since the last CLR or reset.

Function
REQ-016 SHALL drive o_ready = !o_valid || i_ready, combinationally.
REQ-017 SHALL accept an operation only when i_valid && o_ready; when not accepting, all registers SHALL hold.
REQ-018 SHALL have a latency of 1 cycle: an operation accepted at edge N gives o_valid=1 with its result after edge N.
REQ-019 SHALL clear o_valid on an edge where o_valid && i_ready && !(i_valid && o_ready).
REQ-020 SHALL, when a result is consumed and a new operation accepted in the same cycle, load the new result and keep o_valid=1, with no bubble.
REQ-021 SHALL hold o_result and o_carry stable while o_valid && !i_ready.
REQ-022 SHALL, in ADD, set o_result = zero-extend(i_a + i_b) as a (P_WIDTH+1)-bit sum and o_carry = sum bit P_WIDTH; the accumulator is unchanged.
REQ-023 SHALL, in SUB, set o_result = zero-extend((i_a - i_b) mod 2^P_WIDTH) and o_carry = (i_a < i_b); the accumulator is unchanged.
REQ-024 SHALL, in ACC, compute t = o_acc + zero-extend(i_a) in P_ACC_W+1 bits; i_b is ignored.
REQ-025 SHALL, in ACC with no overflow (t < 2^P_ACC_W), load accumulator = o_result = t[P_ACC_W-1:0] and set o_carry=0.
REQ-026 SHALL, in ACC with overflow and P_SAT=0, load accumulator = o_result = t mod 2^P_ACC_W, set o_carry=1 and set o_ovf_sticky=1.
REQ-027 SHALL, in ACC with overflow and P_SAT=1, load accumulator = o_result = all-ones, set o_carry=1 and set o_ovf_sticky=1.
REQ-028 SHALL, in ACC when the accumulator is already saturated and P_SAT=1, report overflow again if i_a != 0.
REQ-029 SHALL, in CLR, load accumulator = 0, o_result = 0, o_carry = 0 and o_ovf_sticky = 0, and produce an output beat like any other mode.
REQ-030 SHALL update o_acc on the same edge as o_result for ACC and CLR.

Reset
REQ-031 SHALL, while i_rst_n=0, immediately force o_valid=0, o_result=0, o_carry=0, o_acc=0 and o_ovf_sticky=0, independent of i_clk.
REQ-032 SHALL, during reset, drive o_ready=1 by REQ-016 and accept no operation.
REQ-033 SHALL discard any pending result on reset; the first accept is allowed on the first rising edge after i_rst_n deasserts.

Verification
REQ-034 SHALL cover, with P_WIDTH=4 and P_ACC_W=8: ADD a=15, b=1, i_ready=1 -> next cycle o_valid=1, o_result=0x10, o_carry=1.
REQ-035 SHALL cover: SUB a=3, b=5 -> o_result=0x0E, o_carry=1; then SUB a=5, b=3 -> o_result=0x02, o_carry=0.
REQ-036 SHALL cover: CLR, then 18 back-to-back ACC a=15 with P_SAT=0 -> beats 1..17 give 15..255 with o_carry=0; beat 18 gives 0x0E, o_carry=1, o_ovf_sticky=1; with P_SAT=1 beat 18 gives 0xFF, o_carry=1.
REQ-037 SHALL cover backpressure: with o_valid=1, hold i_ready=0 for 5 cycles while i_valid=1 -> o_ready=0, o_result unchanged and o_acc unchanged; raising i_ready gives a same-cycle consume plus accept with o_valid staying 1.
REQ-038 SHALL cover reset mid-operation: pulse i_rst_n low between clock edges while o_valid=1 and o_acc=0x40 -> all outputs 0 before the next edge and o_ready=1.
REQ-039 SHALL cover CLR after overflow: with o_ovf_sticky=1, CLR -> o_acc=0, o_ovf_sticky=0, o_result=0, o_valid=1.
